// File: rtl/dll_pkg.sv
// Shared data-link-layer definitions: DLCMSM encoding, DLLP type codes,
// flow-control field widths and small DLLP packing helpers.
package dll_pkg;

    typedef enum logic [1:0] {
        DL_INACTIVE = 2'b00,
        DL_INIT1    = 2'b01,
        DL_INIT2    = 2'b10,
        DL_ACTIVE   = 2'b11
    } dlcmsm_state_e;

    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2
    } fc_class_e;

    localparam int unsigned HDRFC_W  = 8;
    localparam int unsigned DATAFC_W = 12;

    // Type byte = base | (class << 4)
    localparam logic [7:0] DLLP_INITFC1_BASE  = 8'h40;
    localparam logic [7:0] DLLP_INITFC2_BASE  = 8'hC0;
    localparam logic [7:0] DLLP_UPDATEFC_BASE = 8'h80;

    function automatic fc_class_e fc_next(input fc_class_e c);
        case (c)
            FC_P:    return FC_NP;
            FC_NP:   return FC_CPL;
            default: return FC_P;
        endcase
    endfunction

    function automatic logic [7:0] fc_type(input logic [7:0] base, input fc_class_e c);
        return base | {2'b00, c, 4'h0};
    endfunction

    function automatic logic [31:0] fc_word(input logic [7:0] typ,
                                            input logic [HDRFC_W-1:0] hdr,
                                            input logic [DATAFC_W-1:0] dat);
        return {dat[7:0], hdr[1:0], 2'b00, dat[11:8], 2'b00, hdr[7:2], typ};
    endfunction

endpackage

// File: rtl/dll_dllp_crc16.sv
// Combinational DLLP CRC-16 (poly 0x100B, seed 0xFFFF) over bytes 0-3, LSB of
// byte 0 first; output is complemented and bit-reversed, ready for bytes 4-5.
module dll_dllp_crc16 (
    input  logic [31:0] data_i,
    output logic [15:0] crc_o
);

    logic [15:0] rem;

    always_comb begin
        rem = 16'hFFFF;
        for (int unsigned i = 0; i < 32; i++) begin
            if (rem[15] ^ data_i[i]) rem = {rem[14:0], 1'b0} ^ 16'h100B;
            else                     rem = {rem[14:0], 1'b0};
        end
        for (int unsigned k = 0; k < 16; k++) begin
            crc_o[k] = ~rem[15-k];
        end
    end

endmodule

// File: rtl/dll_fc_dllp_tx.sv
// Flow-control DLLP transmitter: turns DLCMSM state into InitFC1/InitFC2/UpdateFC
// DLLPs for VC0 P/NP/Cpl and reports InitFC progress.
module dll_fc_dllp_tx
    import dll_pkg::*;
#(
    parameter logic [HDRFC_W-1:0] INIT_P_HDR    = 8'd16,
    parameter logic [HDRFC_W-1:0] INIT_NP_HDR   = 8'd16,
    parameter logic [HDRFC_W-1:0] INIT_CPL_HDR  = 8'd0,
    parameter int unsigned        UPDATE_PERIOD = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  dlcmsm_state_i,
    input  logic [3:0]  tl_cc_p_i,
    input  logic [3:0]  tl_cc_np_i,
    input  logic [3:0]  tl_cc_cpl_i,
    output logic        dllp_valid_o,
    input  logic        dllp_ready_i,
    output logic [47:0] dllp_data_o,
    output logic        fc_init1_done_o,
    output logic        fc_init2_done_o
);

    typedef enum logic [1:0] {S_IDLE, S_INIT1, S_INIT2, S_ACTIVE} tx_state_e;

    localparam int unsigned TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(UPDATE_PERIOD - 1);
    localparam logic [2:0][HDRFC_W-1:0] INIT_HDR = {INIT_CPL_HDR, INIT_NP_HDR, INIT_P_HDR};

    tx_state_e                 state_q, state_d;
    fc_class_e                 cls_q, cls_d, cls_cur, c0, c1, c2, l_cls;
    logic                      round_q, round_d, round_cur;
    logic [2:0][HDRFC_W-1:0]   cnt_q, cnt_d, adv_q, adv_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic                      valid_q, valid_d;
    logic [47:0]               data_q, data_d;
    logic                      done1_q, done1_d, done2_q, done2_d;
    logic [2:0][3:0]           cc;
    logic [2:0]                pend;
    logic                      free, acc, launch;
    logic [7:0]                l_base;
    logic [31:0]               l_word;
    logic [15:0]               l_crc;

    assign cc     = {tl_cc_cpl_i, tl_cc_np_i, tl_cc_p_i};
    assign l_word = fc_word(fc_type(l_base, l_cls), cnt_q[l_cls], '0);

    dll_dllp_crc16 u_crc (
        .data_i (l_word),
        .crc_o  (l_crc)
    );

    always_comb begin
        case (dlcmsm_state_e'(dlcmsm_state_i))
            DL_INIT1:  state_d = S_INIT1;
            DL_INIT2:  state_d = S_INIT2;
            DL_ACTIVE: state_d = S_ACTIVE;
            default:   state_d = S_IDLE;
        endcase

        // A state change restarts the class sequence at P and abandons any round.
        cls_cur   = (state_d != state_q) ? FC_P : cls_q;
        round_cur = (state_d != state_q) ? 1'b0 : round_q;
        c0 = cls_cur;
        c1 = fc_next(c0);
        c2 = fc_next(c1);

        acc  = valid_q && dllp_ready_i;
        free = !valid_q || dllp_ready_i;
        for (int unsigned c = 0; c < 3; c++) begin
            pend[c]  = (cnt_q[c] != adv_q[c]);
            cnt_d[c] = cnt_q[c] + {4'h0, cc[c]};
        end

        launch  = 1'b0;
        l_cls   = FC_P;
        l_base  = DLLP_UPDATEFC_BASE;
        cls_d   = cls_cur;
        round_d = round_cur;
        adv_d   = adv_q;
        timer_d = TMR_RELOAD;
        valid_d = valid_q && !dllp_ready_i;
        data_d  = data_q;
        done1_d = done1_q || (acc && data_q[7:0] == fc_type(DLLP_INITFC1_BASE, FC_CPL));
        done2_d = done2_q || (acc && data_q[7:0] == fc_type(DLLP_INITFC2_BASE, FC_CPL));

        case (state_d)
            S_INIT1, S_INIT2: begin
                if (free) begin
                    launch = 1'b1;
                    l_cls  = cls_cur;
                    l_base = (state_d == S_INIT1) ? DLLP_INITFC1_BASE : DLLP_INITFC2_BASE;
                    cls_d  = fc_next(cls_cur);
                end
            end
            S_ACTIVE: begin
                timer_d = (timer_q != '0) ? timer_q - 1'b1 : '0;
                if (free) begin
                    if (round_cur) begin
                        launch  = 1'b1;
                        l_cls   = cls_cur;
                        cls_d   = fc_next(cls_cur);
                        round_d = (cls_cur != FC_CPL);
                    end else if (timer_q == '0) begin
                        launch  = 1'b1;
                        l_cls   = FC_P;
                        cls_d   = FC_NP;
                        round_d = 1'b1;
                        timer_d = TMR_RELOAD;
                    end else if (pend[c0]) begin
                        launch = 1'b1;
                        l_cls  = c0;
                        cls_d  = c1;
                    end else if (pend[c1]) begin
                        launch = 1'b1;
                        l_cls  = c1;
                        cls_d  = c2;
                    end else if (pend[c2]) begin
                        launch = 1'b1;
                        l_cls  = c2;
                        cls_d  = c0;
                    end
                end
            end
            default: ;
        endcase

        if (launch) begin
            valid_d       = 1'b1;
            data_d        = {l_crc, l_word};
            adv_d[l_cls]  = cnt_q[l_cls];
        end

        if (state_d == S_IDLE) begin
            valid_d = 1'b0;
            data_d  = '0;
            cnt_d   = INIT_HDR;
            adv_d   = INIT_HDR;
            done1_d = 1'b0;
            done2_d = 1'b0;
            cls_d   = FC_P;
            round_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cls_q   <= FC_P;
            round_q <= 1'b0;
            cnt_q   <= INIT_HDR;
            adv_q   <= INIT_HDR;
            timer_q <= TMR_RELOAD;
            valid_q <= 1'b0;
            data_q  <= '0;
            done1_q <= 1'b0;
            done2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            adv_q   <= adv_d;
            timer_q <= timer_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            done1_q <= done1_d;
            done2_q <= done2_d;
        end
    end

    assign dllp_valid_o    = valid_q;
    assign dllp_data_o     = data_q;
    assign fc_init1_done_o = done1_q;
    assign fc_init2_done_o = done2_q;

endmodule

// File: tb/tb_dll_fc_dllp_tx.sv
// Directed self-checking bench for dll_fc_dllp_tx: InitFC sequencing, state
// switch while held, UpdateFC on credits/timer, counter wrap and DL_INACTIVE.
module tb_dll_fc_dllp_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  dlcmsm_state = 2'b00;
    logic [3:0]  cc_p = '0, cc_np = '0, cc_cpl = '0;
    logic        dllp_valid;
    logic        dllp_ready = 1'b0;
    logic [47:0] dllp_data;
    logic        init1_done, init2_done;

    int pass_cnt = 0;
    int total    = 0;

    dll_fc_dllp_tx #(
        .INIT_P_HDR    (8'd16),
        .INIT_NP_HDR   (8'd16),
        .INIT_CPL_HDR  (8'd0),
        .UPDATE_PERIOD (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dlcmsm_state_i  (dlcmsm_state),
        .tl_cc_p_i       (cc_p),
        .tl_cc_np_i      (cc_np),
        .tl_cc_cpl_i     (cc_cpl),
        .dllp_valid_o    (dllp_valid),
        .dllp_ready_i    (dllp_ready),
        .dllp_data_o     (dllp_data),
        .fc_init1_done_o (init1_done),
        .fc_init2_done_o (init2_done)
    );

    always #5 clk = ~clk;

    // Reference DLLP: bytes 0-3 packed by hand, CRC computed bit-serially.
    function automatic logic [47:0] exp_dllp(input logic [7:0] t, input logic [7:0] h);
        logic [31:0] w;
        logic [15:0] c;
        logic [7:0]  b4, b5;
        w = {8'h00, h[1:0], 6'b000000, 2'b00, h[7:2], t};
        c = 16'hFFFF;
        for (int n = 0; n < 4; n++) begin
            for (int b = 0; b < 8; b++) begin
                if (c[15] ^ w[8*n+b]) c = (c << 1) ^ 16'h100B;
                else                  c = c << 1;
            end
        end
        c = ~c;
        for (int b = 0; b < 8; b++) begin
            b4[b] = c[15-b];
            b5[b] = c[7-b];
        end
        return {b5, b4, w};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        total++; if (dllp_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dllp_valid); else pass_cnt++;
        total++; if (dllp_data !== 48'h0) $display("FAIL reset_data got %h want 0", dllp_data); else pass_cnt++;
        total++; if (init1_done !== 1'b0) $display("FAIL reset_done1 got %b want 0", init1_done); else pass_cnt++;
        total++; if (init2_done !== 1'b0) $display("FAIL reset_done2 got %b want 0", init2_done); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_init1;
        logic [7:0] typs [3];
        logic [7:0] hdrs [3];
        typs = '{8'h40, 8'h50, 8'h60};
        hdrs = '{8'd16, 8'd16, 8'd0};
        dllp_ready   = 1'b1;
        dlcmsm_state = 2'b01;
        #1;
        total++; if (dllp_valid !== 1'b0) $display("FAIL init1_pre_valid got %b want 0", dllp_valid); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dllp_valid !== 1'b1 || dllp_data !== exp_dllp(typs[i], hdrs[i]))
                $display("FAIL init1_dllp%0d got v=%b %h want v=1 %h", i, dllp_valid, dllp_data, exp_dllp(typs[i], hdrs[i]));
            else pass_cnt++;
        end
        total++; if (init1_done !== 1'b0) $display("FAIL init1_done_early got %b want 0", init1_done); else pass_cnt++;
        tick();
        total++; if (init1_done !== 1'b1) $display("FAIL init1_done got %b want 1", init1_done); else pass_cnt++;
        total++; if (dllp_data !== exp_dllp(8'h40, 8'd16)) $display("FAIL init1_repeat got %h want %h", dllp_data, exp_dllp(8'h40, 8'd16)); else pass_cnt++;
    endtask

    task automatic test_init2_switch;
        logic [7:0] typs [3];
        logic [7:0] hdrs [3];
        typs = '{8'hC0, 8'hD0, 8'hE0};
        hdrs = '{8'd16, 8'd16, 8'd0};
        dllp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) dlcmsm_state = 2'b10;
            tick();
            total++;
            if (dllp_valid !== 1'b1 || dllp_data !== exp_dllp(8'h40, 8'd16))
                $display("FAIL held_p%0d got v=%b %h want v=1 %h", i, dllp_valid, dllp_data, exp_dllp(8'h40, 8'd16));
            else pass_cnt++;
        end
        dllp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dllp_valid !== 1'b1 || dllp_data !== exp_dllp(typs[i], hdrs[i]))
                $display("FAIL init2_dllp%0d got v=%b %h want v=1 %h", i, dllp_valid, dllp_data, exp_dllp(typs[i], hdrs[i]));
            else pass_cnt++;
        end
        total++; if (init2_done !== 1'b0) $display("FAIL init2_done_early got %b want 0", init2_done); else pass_cnt++;
        tick();
        total++; if (init2_done !== 1'b1) $display("FAIL init2_done got %b want 1", init2_done); else pass_cnt++;
        total++; if (init1_done !== 1'b1) $display("FAIL init1_done_kept got %b want 1", init1_done); else pass_cnt++;
    endtask

    task automatic test_active_credit;
        int n;
        dlcmsm_state = 2'b11;
        tick();
        total++; if (dllp_valid !== 1'b0) $display("FAIL active_idle got %b want 0", dllp_valid); else pass_cnt++;
        cc_p = 4'd3;
        tick();
        cc_p = 4'd0;
        total++; if (dllp_valid !== 1'b0) $display("FAIL active_cc_lat got %b want 0", dllp_valid); else pass_cnt++;
        tick();
        total++;
        if (dllp_valid !== 1'b1 || dllp_data !== exp_dllp(8'h80, 8'd19))
            $display("FAIL update_p got v=%b %h want v=1 %h", dllp_valid, dllp_data, exp_dllp(8'h80, 8'd19));
        else pass_cnt++;
        n = 0;
        do begin
            tick();
            n++;
        end while (!dllp_valid && n < 200);
        total++; if (n !== 61) $display("FAIL first_round_delay got %0d want 61", n); else pass_cnt++;
        total++;
        if (dllp_data !== exp_dllp(8'h80, 8'd19))
            $display("FAIL round1_p got %h want %h", dllp_data, exp_dllp(8'h80, 8'd19));
        else pass_cnt++;
        tick();
        total++; if (dllp_data !== exp_dllp(8'h90, 8'd16)) $display("FAIL round1_np got %h want %h", dllp_data, exp_dllp(8'h90, 8'd16)); else pass_cnt++;
        tick();
        total++; if (dllp_data !== exp_dllp(8'hA0, 8'd0)) $display("FAIL round1_cpl got %h want %h", dllp_data, exp_dllp(8'hA0, 8'd0)); else pass_cnt++;
    endtask

    task automatic test_periodic;
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!dllp_valid && n < 200);
        total++; if (n !== 62) $display("FAIL period_gap got %0d want 62", n); else pass_cnt++;
        total++; if (dllp_data !== exp_dllp(8'h80, 8'd19)) $display("FAIL round2_p got %h want %h", dllp_data, exp_dllp(8'h80, 8'd19)); else pass_cnt++;
        tick();
        total++; if (dllp_data !== exp_dllp(8'h90, 8'd16)) $display("FAIL round2_np got %h want %h", dllp_data, exp_dllp(8'h90, 8'd16)); else pass_cnt++;
        tick();
        total++; if (dllp_data !== exp_dllp(8'hA0, 8'd0)) $display("FAIL round2_cpl got %h want %h", dllp_data, exp_dllp(8'hA0, 8'd0)); else pass_cnt++;
    endtask

    task automatic test_wrap;
        dllp_ready = 1'b0;
        cc_p = 4'd15;
        repeat (15) tick();
        cc_p = 4'd6;
        tick();
        cc_p = 4'd10;
        tick();
        cc_p = 4'd0;
        total++;
        if (dllp_valid !== 1'b1 || dllp_data !== exp_dllp(8'hA0, 8'd0))
            $display("FAIL wrap_hold got v=%b %h want v=1 %h", dllp_valid, dllp_data, exp_dllp(8'hA0, 8'd0));
        else pass_cnt++;
        dllp_ready = 1'b1;
        tick();
        total++;
        if (dllp_valid !== 1'b1 || dllp_data !== exp_dllp(8'h80, 8'd4))
            $display("FAIL wrap_p got v=%b %h want v=1 %h", dllp_valid, dllp_data, exp_dllp(8'h80, 8'd4));
        else pass_cnt++;
        tick();
        total++; if (dllp_valid !== 1'b0) $display("FAIL coalesce got %b want 0", dllp_valid); else pass_cnt++;
    endtask

    task automatic test_inactive;
        dllp_ready = 1'b0;
        cc_np = 4'd1;
        tick();
        cc_np = 4'd0;
        tick();
        total++;
        if (dllp_valid !== 1'b1 || dllp_data !== exp_dllp(8'h90, 8'd17))
            $display("FAIL np_update got v=%b %h want v=1 %h", dllp_valid, dllp_data, exp_dllp(8'h90, 8'd17));
        else pass_cnt++;
        tick();
        total++; if (dllp_data !== exp_dllp(8'h90, 8'd17)) $display("FAIL np_stable got %h want %h", dllp_data, exp_dllp(8'h90, 8'd17)); else pass_cnt++;
        dlcmsm_state = 2'b00;
        tick();
        total++; if (dllp_valid !== 1'b0) $display("FAIL inact_valid got %b want 0", dllp_valid); else pass_cnt++;
        total++; if (init1_done !== 1'b0) $display("FAIL inact_done1 got %b want 0", init1_done); else pass_cnt++;
        total++; if (init2_done !== 1'b0) $display("FAIL inact_done2 got %b want 0", init2_done); else pass_cnt++;
        dlcmsm_state = 2'b01;
        dllp_ready   = 1'b1;
        tick();
        total++; if (dllp_data !== exp_dllp(8'h40, 8'd16)) $display("FAIL reload_p got %h want %h", dllp_data, exp_dllp(8'h40, 8'd16)); else pass_cnt++;
        tick();
        total++; if (dllp_data !== exp_dllp(8'h50, 8'd16)) $display("FAIL reload_np got %h want %h", dllp_data, exp_dllp(8'h50, 8'd16)); else pass_cnt++;
        tick();
        total++; if (dllp_data !== exp_dllp(8'h60, 8'd0)) $display("FAIL reload_cpl got %h want %h", dllp_data, exp_dllp(8'h60, 8'd0)); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_init1();
        test_init2_switch();
        test_active_credit();
        test_periodic();
        test_wrap();
        test_inactive();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
